// File: rtl/spectrum_pattern_gen_pkg.sv
// Shared colours, screen geometry and region decode for the spectrum renderer.
// Optional grey grid in the FFT half: define SPECTRUM_GRID_EN.
package spectrum_pkg;

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] GREY   = 24'h404040;

  localparam int SPLIT_Y      = 240;
  localparam int TRACE_CENTER = 360;
  localparam int MAX_BAR      = 239;
  localparam int WIN_X        = 512;

  typedef enum logic [2:0] {
    RG_OFF,
    RG_DIV,
    RG_BLANK,
    RG_FFT,
    RG_AUD
  } region_t;

  // First match wins, so this is a priority chain
  function automatic region_t region_of(
    input logic       de,
    input logic [9:0] x,
    input logic [9:0] y
  );
    region_t r;
    if (!de)
      r = RG_OFF;
    else if (y == 10'(SPLIT_Y))
      r = RG_DIV;
    else if (x >= 10'(WIN_X))
      r = RG_BLANK;
    else if (y < 10'(SPLIT_Y))
      r = RG_FFT;
    else
      r = RG_AUD;
    return r;
  endfunction

endpackage

// File: rtl/spectrum_pattern_gen_if.sv
// Video-timing, RAM-fetch and pixel-output bundle of the spectrum renderer.
// Master drives timing and RAM data; slave is the renderer.
interface spectrum_pattern_gen_if #(
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10,
  parameter int COLOR_DEPTH = 8
);
  logic [X_BITS-1:0]      act_x;
  logic [Y_BITS-1:0]      act_y;
  logic                   vs_in;
  logic                   hs_in;
  logic                   de_in;
  logic [31:0]            fft_data;
  logic                   data_req;
  logic [9:0]             RAM_address;
  logic                   en_flag;
  logic                   vs_out;
  logic                   hs_out;
  logic                   de_out;
  logic [COLOR_DEPTH-1:0] r_out;
  logic [COLOR_DEPTH-1:0] g_out;
  logic [COLOR_DEPTH-1:0] b_out;

  modport master (
    output act_x, act_y, vs_in, hs_in, de_in, fft_data,
    input  data_req, RAM_address, en_flag,
    input  vs_out, hs_out, de_out, r_out, g_out, b_out
  );

  modport slave (
    input  act_x, act_y, vs_in, hs_in, de_in, fft_data,
    output data_req, RAM_address, en_flag,
    output vs_out, hs_out, de_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/spectrum_pattern_gen_fft_mag_abs.sv
// L1 magnitude |re|+|im| of a signed complex bin.
// 17-bit result so |-32768| + |-32768| = 65536 fits.
module fft_mag_abs (
  input  logic [15:0] re,
  input  logic [15:0] im,
  output logic [16:0] mag
);

  logic [16:0] abs_re;
  logic [16:0] abs_im;

  // Sign-extend to 17 bits before negating so -32768 maps to 32768
  always_comb begin
    abs_re = re[15] ? 17'd0 - {re[15], re} : {1'b0, re};
    abs_im = im[15] ? 17'd0 - {im[15], im} : {1'b0, im};
    mag    = abs_re + abs_im;
  end

endmodule

// File: rtl/spectrum_pattern_gen.sv
// FFT bar graph (upper half) and audio trace (lower half) renderer.
// Optional grid: define SPECTRUM_GRID_EN.
module spectrum_pattern_gen
  import spectrum_pkg::*;
#(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int FFT_POINT   = 256,
  parameter int MAG_SHIFT   = 8,
  parameter int AUDIO_BASE  = 256
) (
  input logic pix_clk,
  input logic rst,
  spectrum_pattern_gen_if.slave bus
);

  logic [X_BITS-1:0] x0;
  logic [Y_BITS-1:0] y0;
  logic              de0;
  logic              vs0;
  logic              hs0;
  logic              req0;
  logic              en0;
  logic [9:0]        addr0;

  logic [16:0]        mag;
  logic [16:0]        scaled;
  logic [7:0]         height;
  logic signed [15:0] sample;
  logic signed [15:0] offset;
  logic signed [11:0] trace_y;
  logic signed [11:0] dy;
  logic               near;
  logic               bar;
  region_t            region;
  logic [23:0]        pix;

  logic        vs2;
  logic        hs2;
  logic        de2;
  logic [23:0] rgb2;

  logic audio_in;
  logic win_in;

  assign audio_in = bus.act_y >= Y_BITS'(V_ACT / 2);
  assign win_in   = bus.de_in && (bus.act_x < X_BITS'(2 * FFT_POINT));

  // Stage 0: capture coordinates/syncs and issue the RAM read
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      x0    <= '0;
      y0    <= '0;
      de0   <= 1'b0;
      vs0   <= 1'b0;
      hs0   <= 1'b0;
      req0  <= 1'b0;
      en0   <= 1'b0;
      addr0 <= '0;
    end else begin
      x0   <= bus.act_x;
      y0   <= bus.act_y;
      de0  <= bus.de_in;
      vs0  <= bus.vs_in;
      hs0  <= bus.hs_in;
      en0  <= audio_in;
      req0 <= win_in;
      if (win_in)
        addr0 <= {2'b00, bus.act_x[8:1]}
               + (audio_in ? 10'(AUDIO_BASE) : 10'd0);
      else
        addr0 <= '0;
    end
  end

  fft_mag_abs u_mag (
    .re  (bus.fft_data[15:0]),
    .im  (bus.fft_data[31:16]),
    .mag (mag)
  );

  // Stage 1: bar height, trace position and pixel colour
  always_comb begin
    scaled  = mag >> MAG_SHIFT;
    height  = (scaled > 17'(MAX_BAR)) ? 8'(MAX_BAR) : scaled[7:0];
    sample  = $signed(bus.fft_data[15:0]);
    offset  = sample >>> 9;
    trace_y = 12'(TRACE_CENTER) - offset[11:0];
    dy      = $signed({2'b00, 10'(y0)}) - trace_y;
    near    = (dy >= -12'sd1) && (dy <= 12'sd1);
    bar     = (height != 8'd0)
           && ((10'(MAX_BAR) - 10'(y0)) <= {2'b00, height});
    region  = region_of(de0, 10'(x0), 10'(y0));
    pix     = BLACK;
    unique case (region)
      RG_OFF:   pix = BLACK;
      RG_DIV:   pix = WHITE;
      RG_BLANK: pix = BLACK;
      RG_FFT: begin
        if (bar)
          pix = GREEN;
`ifdef SPECTRUM_GRID_EN
        else if ((x0[5:0] == 6'd0) || (y0[5:0] == 6'd0))
          pix = GREY;
`endif
        else
          pix = BLACK;
      end
      RG_AUD:   pix = near ? YELLOW : BLACK;
      default:  pix = BLACK;
    endcase
  end

  // Stage 2: register pixel alongside the twice-delayed syncs
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vs2  <= 1'b0;
      hs2  <= 1'b0;
      de2  <= 1'b0;
      rgb2 <= '0;
    end else begin
      vs2  <= vs0;
      hs2  <= hs0;
      de2  <= de0;
      rgb2 <= pix;
    end
  end

  assign bus.data_req    = req0;
  assign bus.en_flag     = en0;
  assign bus.RAM_address = addr0;
  assign bus.vs_out      = vs2;
  assign bus.hs_out      = hs2;
  assign bus.de_out      = de2;
  assign bus.r_out       = COLOR_DEPTH'(rgb2[23:16]);
  assign bus.g_out       = COLOR_DEPTH'(rgb2[15:8]);
  assign bus.b_out       = COLOR_DEPTH'(rgb2[7:0]);

endmodule

// File: tb/tb_spectrum_pattern_gen.sv
// Randomised bench for spectrum_pattern_gen against a screen-rule model.
// Grid expectations follow SPECTRUM_GRID_EN when defined.
module tb_spectrum_pattern_gen;

  logic pix_clk = 1'b0;
  logic rst = 1'b1;

  always #5 pix_clk = ~pix_clk;

  spectrum_pattern_gen_if bus ();

  spectrum_pattern_gen dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    bit          v;
    int          x;
    int          y;
    bit          de;
    bit          vs;
    bit          hs;
    logic [31:0] f;
  } stim_t;

  int total = 0;
  int bad = 0;
  stim_t s1;
  stim_t s2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int floor512(input int v);
    if (v >= 0) return v / 512;
    return -((-v + 511) / 512);
  endfunction

  function automatic logic [31:0] ref_ram(input stim_t s);
    bit en;
    int addr;
    bit req;
    en = (s.y >= 240);
    req = s.de && (s.x < 512);
    addr = req ? (s.x / 2 + (en ? 256 : 0)) : 0;
    return {20'd0, req, en, addr[9:0]};
  endfunction

  function automatic logic [31:0] ref_pix(input stim_t s);
    int re, im, h, off, ty;
    if (!s.de) return 32'h000000;
    if (s.y == 240) return 32'hFFFFFF;
    if (s.x >= 512) return 32'h000000;
    if (s.y < 240) begin
      re = int'($signed(s.f[15:0]));
      im = int'($signed(s.f[31:16]));
      h = (iabs(re) + iabs(im)) / 256;
      if (h > 239) h = 239;
      if (h != 0 && (239 - s.y) <= h) return 32'h00FF00;
`ifdef SPECTRUM_GRID_EN
      if (s.x % 64 == 0 || s.y % 64 == 0) return 32'h404040;
`endif
      return 32'h000000;
    end
    off = floor512(int'($signed(s.f[15:0])));
    ty = 360 - off;
    if (iabs(s.y - ty) <= 1) return 32'hFFFF00;
    return 32'h000000;
  endfunction

  function automatic logic [31:0] ram_obs();
    return {20'd0, bus.data_req, bus.en_flag, bus.RAM_address};
  endfunction

  function automatic logic [31:0] pix_obs();
    return {8'd0, bus.r_out, bus.g_out, bus.b_out};
  endfunction

  function automatic logic [31:0] sync_obs();
    return {29'd0, bus.vs_out, bus.hs_out, bus.de_out};
  endfunction

  // One pixel clock: check outputs, then present the next pixel.
  // f is the RAM word that belongs to this pixel; it is driven one
  // cycle later, matching the one-cycle RAM latency.
  task automatic step(input int x, input int y, input bit de,
                      input bit vs, input bit hs, input logic [31:0] f);
    stim_t n;
    @(posedge pix_clk);
    #1;
    if (rst) begin
      check("rst_ram", ram_obs(), 32'd0);
      check("rst_sync", sync_obs(), 32'd0);
      check("rst_pix", pix_obs(), 32'd0);
    end else begin
      if (s1.v) check("ram", ram_obs(), ref_ram(s1));
      if (s2.v) begin
        check("sync", sync_obs(), {29'd0, s2.vs, s2.hs, s2.de});
        check("pix", pix_obs(), ref_pix(s2));
      end
    end
    s2 = s1;
    n.v = !rst;
    n.x = x;
    n.y = y;
    n.de = de;
    n.vs = vs;
    n.hs = hs;
    n.f = f;
    s1 = n;
    bus.act_x = x[9:0];
    bus.act_y = y[9:0];
    bus.de_in = de;
    bus.vs_in = vs;
    bus.hs_in = hs;
    bus.fft_data = s2.f;
  endtask

  task automatic rand_step();
    int x, y, d, off, smp;
    bit de;
    logic [31:0] f;
    logic [15:0] re, im;
    x = $urandom_range(0, 639);
    y = ($urandom_range(0, 9) == 0) ? 240 : $urandom_range(0, 479);
    de = ($urandom_range(0, 9) != 0);
    if (y < 240) begin
      re = 16'($urandom) >> $urandom_range(0, 15);
      im = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) re = 16'd0 - re;
      if ($urandom_range(0, 1) == 1) im = 16'd0 - im;
      if ($urandom_range(0, 15) == 0) re = 16'h8000;
      f = {im, re};
    end else begin
      d = $urandom_range(0, 6) - 3;
      off = 360 - y + d;
      if (off > 63) off = 63;
      if (off < -64) off = -64;
      smp = off * 512 + $urandom_range(0, 511);
      f = {16'($urandom), smp[15:0]};
    end
    step(x, y, de, 1'($urandom), 1'($urandom), f);
  endtask

  initial begin
    s1 = '{v: 1'b0, x: 0, y: 0, de: 1'b0, vs: 1'b0, hs: 1'b0, f: '0};
    s2 = s1;
    bus.act_x = '0;
    bus.act_y = '0;
    bus.de_in = 1'b0;
    bus.vs_in = 1'b0;
    bus.hs_in = 1'b0;
    bus.fft_data = '0;

    repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 32'd0);
    rst = 1'b0;

    repeat (4) step(0, 0, 1'b0, 1'b0, 1'b1, 32'd0);
    step(0, 0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);

    for (int r = 0; r < 2; r++) begin
      step(10, 100, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
      step(10, 230, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
      step(11, 230, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
      step(20, 0, 1'b1, 1'b0, 1'b0, 32'h8000_8000);
      step(20, 120, 1'b1, 1'b0, 1'b0, 32'h8000_8000);
      step(21, 239, 1'b1, 1'b0, 1'b0, 32'h8000_8000);
      step(20, 240, 1'b1, 1'b0, 1'b0, 32'h8000_8000);
      step(20, 300, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step(20, 355, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step(20, 356, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step(20, 357, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step(20, 358, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step(600, 100, 1'b1, 1'b0, 1'b0, 32'h8000_8000);
      step(600, 300, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step(64, 10, 1'b1, 1'b0, 1'b0, 32'd0);
      step(30, 64, 1'b1, 1'b0, 1'b0, 32'd0);
      step(511, 479, 1'b1, 1'b0, 1'b0, 32'h0000_8000);
      step(10, 100, 1'b0, 1'b1, 1'b1, 32'h8000_8000);
    end

    repeat (1500) rand_step();

    @(posedge pix_clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_ram", ram_obs(), 32'd0);
    check("async_sync", sync_obs(), 32'd0);
    check("async_pix", pix_obs(), 32'd0);
    s1.v = 1'b0;
    s2.v = 1'b0;
    repeat (3) rand_step();
    rst = 1'b0;

    repeat (1500) rand_step();
    repeat (2) step(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
